// File: rtl/regfile_port_arbiter.sv
// Write-port arbiter, read bypass and $0 handling between pipeline/debug and a 32x32 register file.
// Also hosts a sequential dump engine that streams every register to the debug unit.
module regfile_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pl_rd_en,
    input  logic [ADDR_W-1:0] pl_rs,
    input  logic [ADDR_W-1:0] pl_rt,
    input  logic              pl_we,
    input  logic [ADDR_W-1:0] pl_wa,
    input  logic [DATA_W-1:0] pl_wd,
    output logic [DATA_W-1:0] pl_rs_data,
    output logic [DATA_W-1:0] pl_rt_data,
    output logic              pl_rd_valid,
    output logic              pl_stall,
    input  logic              dbg_wr_valid,
    output logic              dbg_wr_ready,
    input  logic [ADDR_W-1:0] dbg_wa,
    input  logic [DATA_W-1:0] dbg_wd,
    input  logic              dbg_dump_start,
    output logic              dbg_dump_busy,
    output logic              dbg_dump_valid,
    input  logic              dbg_dump_ready,
    output logic [ADDR_W-1:0] dbg_dump_idx,
    output logic [DATA_W-1:0] dbg_dump_data,
    output logic [ADDR_W-1:0] rf_a1,
    output logic [ADDR_W-1:0] rf_a2,
    output logic [ADDR_W-1:0] rf_a3,
    output logic [DATA_W-1:0] rf_wd3,
    output logic              rf_we3,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, VALID} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] idx_reg, idx_next;
    logic              rd_valid_reg;
    logic [DATA_W-1:0] byp_data_reg;
    logic              dump_hit_reg;
    logic [ADDR_W-1:0] dump_idx_reg;
    logic [DATA_W-1:0] dump_data_reg;
    logic              rd_accept;
    logic [DATA_W-1:0] rd_data [2];

    // Pipeline owns the write port whenever it writes; debug only gets idle slots.
    assign dbg_wr_ready = reset & ~pl_we;
    assign rf_a3        = pl_we ? pl_wa : dbg_wa;
    assign rf_wd3       = pl_we ? pl_wd : dbg_wd;
    assign rf_we3       = (pl_we | (dbg_wr_valid & dbg_wr_ready)) & (rf_a3 != '0);

    assign rf_a1     = (state_reg == ISSUE) ? idx_reg : pl_rs;
    assign rf_a2     = pl_rt;
    assign rd_accept = pl_rd_en & (state_reg == IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid_reg <= 1'b0;
            byp_data_reg <= '0;
        end else begin
            rd_valid_reg <= rd_accept;
            byp_data_reg <= rf_wd3;
        end
    end

    // The register file returns pre-write data on a same-cycle collision, so each port remembers
    // whether its address matched the write issued alongside the request.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [ADDR_W-1:0] req_addr;
            logic [DATA_W-1:0] rf_data;
            logic [ADDR_W-1:0] addr_reg;
            logic              hit_reg;
            logic [DATA_W-1:0] hold_reg;
            logic [DATA_W-1:0] fresh;

            assign req_addr = (gi == 0) ? pl_rs : pl_rt;
            assign rf_data  = (gi == 0) ? rf_rd1 : rf_rd2;

            always_comb begin
                fresh = rf_data;
                if (addr_reg == '0) begin
                    fresh = '0;
                end else if (hit_reg) begin
                    fresh = byp_data_reg;
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    addr_reg <= '0;
                    hit_reg  <= 1'b0;
                    hold_reg <= '0;
                end else begin
                    if (rd_accept) begin
                        addr_reg <= req_addr;
                        hit_reg  <= rf_we3 && (rf_a3 == req_addr);
                    end
                    if (rd_valid_reg) begin
                        hold_reg <= fresh;
                    end
                end
            end

            assign rd_data[gi] = rd_valid_reg ? fresh : hold_reg;
        end
    endgenerate

    assign pl_rs_data  = rd_data[0];
    assign pl_rt_data  = rd_data[1];
    assign pl_rd_valid = rd_valid_reg;

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        unique case (state_reg)
            IDLE: begin
                if (dbg_dump_start) begin
                    state_next = ISSUE;
                    idx_next   = '0;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT:  state_next = VALID;
            VALID: begin
                if (dbg_dump_ready) begin
                    if (idx_reg == LAST_IDX) begin
                        state_next = IDLE;
                    end else begin
                        idx_next   = idx_reg + 1'b1;
                        state_next = ISSUE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            dump_hit_reg  <= 1'b0;
            dump_idx_reg  <= '0;
            dump_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            dump_hit_reg <= rf_we3 && (rf_a3 == idx_reg);
            if (state_reg == WAIT) begin
                dump_idx_reg <= idx_reg;
                if (idx_reg == '0) begin
                    dump_data_reg <= '0;
                end else if (dump_hit_reg) begin
                    dump_data_reg <= byp_data_reg;
                end else begin
                    dump_data_reg <= rf_rd1;
                end
            end
        end
    end

    assign pl_stall       = (state_reg != IDLE);
    assign dbg_dump_busy  = (state_reg != IDLE);
    assign dbg_dump_valid = (state_reg == VALID);
    assign dbg_dump_idx   = dump_idx_reg;
    assign dbg_dump_data  = dump_data_reg;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter with a read-first register file model and scoreboard queues.
module tb_regfile_port_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          pl_rd_en, pl_we, dbg_wr_valid, dbg_dump_start, dbg_dump_ready;
    logic [AW-1:0] pl_rs, pl_rt, pl_wa, dbg_wa;
    logic [DW-1:0] pl_wd, dbg_wd;
    logic [DW-1:0] pl_rs_data, pl_rt_data, dbg_dump_data, rf_wd3, rf_rd1, rf_rd2;
    logic          pl_rd_valid, pl_stall, dbg_wr_ready, dbg_dump_busy, dbg_dump_valid, rf_we3;
    logic [AW-1:0] dbg_dump_idx, rf_a1, rf_a2, rf_a3;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [DW-1:0]    rf_mem   [NR];
    logic [DW-1:0]    ref_regs [NR];
    logic [2*DW-1:0]  rd_q   [$];
    logic [AW+DW-1:0] dump_q [$];
    logic [2*DW-1:0]  rd_exp;
    logic [AW+DW-1:0] dump_exp;

    regfile_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NREGS(NR)) dut (
        .clk(clk), .reset(reset),
        .pl_rd_en(pl_rd_en), .pl_rs(pl_rs), .pl_rt(pl_rt),
        .pl_we(pl_we), .pl_wa(pl_wa), .pl_wd(pl_wd),
        .pl_rs_data(pl_rs_data), .pl_rt_data(pl_rt_data),
        .pl_rd_valid(pl_rd_valid), .pl_stall(pl_stall),
        .dbg_wr_valid(dbg_wr_valid), .dbg_wr_ready(dbg_wr_ready),
        .dbg_wa(dbg_wa), .dbg_wd(dbg_wd),
        .dbg_dump_start(dbg_dump_start), .dbg_dump_busy(dbg_dump_busy),
        .dbg_dump_valid(dbg_dump_valid), .dbg_dump_ready(dbg_dump_ready),
        .dbg_dump_idx(dbg_dump_idx), .dbg_dump_data(dbg_dump_data),
        .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_a3(rf_a3),
        .rf_wd3(rf_wd3), .rf_we3(rf_we3),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2)
    );

    always #5 clk = ~clk;

    // Register file model: registered reads return pre-write data on a collision.
    always @(posedge clk) begin
        rf_rd1 <= rf_mem[rf_a1];
        rf_rd2 <= rf_mem[rf_a2];
        if (rf_we3) rf_mem[rf_a3] <= rf_wd3;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pl_rd_en = 0; pl_rs = '0; pl_rt = '0;
        pl_we = 0; pl_wa = '0; pl_wd = '0;
        dbg_wr_valid = 0; dbg_wa = '0; dbg_wd = '0;
        dbg_dump_start = 0; dbg_dump_ready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 0;
        tick(); tick();
        chk_cnt++; if (pl_rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b want 0", pl_rd_valid); else pass_cnt++;
        chk_cnt++; if (pl_rs_data !== '0) $display("FAIL reset_rs_data: got %h want 0", pl_rs_data); else pass_cnt++;
        chk_cnt++; if (pl_rt_data !== '0) $display("FAIL reset_rt_data: got %h want 0", pl_rt_data); else pass_cnt++;
        chk_cnt++; if (pl_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", pl_stall); else pass_cnt++;
        chk_cnt++; if (dbg_dump_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", dbg_dump_busy); else pass_cnt++;
        chk_cnt++; if (dbg_dump_valid !== 1'b0) $display("FAIL reset_dump_valid: got %b want 0", dbg_dump_valid); else pass_cnt++;
        chk_cnt++; if (dbg_dump_idx !== '0) $display("FAIL reset_dump_idx: got %h want 0", dbg_dump_idx); else pass_cnt++;
        chk_cnt++; if (dbg_dump_data !== '0) $display("FAIL reset_dump_data: got %h want 0", dbg_dump_data); else pass_cnt++;
        chk_cnt++; if (dbg_wr_ready !== 1'b0) $display("FAIL reset_wr_ready: got %b want 0", dbg_wr_ready); else pass_cnt++;
        reset = 1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_write_read();
        pl_we = 1; pl_wa = 5; pl_wd = 32'hDEADBEEF; ref_regs[5] = 32'hDEADBEEF;
        #1;
        chk_cnt++; if (rf_we3 !== 1'b1 || rf_a3 !== 5'd5 || rf_wd3 !== 32'hDEADBEEF)
            $display("FAIL wr_port: got we=%b a=%0d d=%h want 1/5/deadbeef", rf_we3, rf_a3, rf_wd3); else pass_cnt++;
        tick();
        pl_we = 0; pl_rd_en = 1; pl_rs = 5; pl_rt = 0;
        rd_q.push_back({ref_regs[5], ref_regs[0]});
        tick();
        pl_rd_en = 0;
        chk_cnt++; if (pl_rd_valid !== 1'b1) $display("FAIL wr_rd_valid: got %b want 1", pl_rd_valid); else pass_cnt++;
        if (rd_q.size() > 0) begin
            rd_exp = rd_q.pop_front();
            chk_cnt++; if (pl_rs_data !== rd_exp[2*DW-1:DW]) $display("FAIL wr_rd_rs: got %h want %h", pl_rs_data, rd_exp[2*DW-1:DW]); else pass_cnt++;
            chk_cnt++; if (pl_rt_data !== rd_exp[DW-1:0]) $display("FAIL wr_rd_rt: got %h want %h", pl_rt_data, rd_exp[DW-1:0]); else pass_cnt++;
        end
        tick();
        chk_cnt++; if (pl_rd_valid !== 1'b0) $display("FAIL wr_rd_valid_drop: got %b want 0", pl_rd_valid); else pass_cnt++;
        chk_cnt++; if (pl_rs_data !== 32'hDEADBEEF) $display("FAIL wr_rd_hold: got %h want deadbeef", pl_rs_data); else pass_cnt++;
        $display("test_write_read done");
    endtask

    task automatic test_bypass();
        logic [AW-1:0] ra [3];
        logic [AW-1:0] rb [3];
        logic [AW-1:0] wa [3];
        logic [DW-1:0] wd [3];
        logic          use_dbg [3];
        pl_we = 1; pl_wa = 7; pl_wd = 32'h0BAD0007; ref_regs[7] = 32'h0BAD0007;
        tick();
        ra = '{5'd7, 5'd7, 5'd11}; rb = '{5'd7, 5'd8, 5'd0};
        wa = '{5'd7, 5'd8, 5'd11};
        wd = '{32'h12345678, 32'h87654321, 32'h0000D011};
        use_dbg = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            pl_we = !use_dbg[i]; pl_wa = wa[i]; pl_wd = wd[i];
            dbg_wr_valid = use_dbg[i]; dbg_wa = wa[i]; dbg_wd = wd[i];
            ref_regs[wa[i]] = wd[i];
            pl_rd_en = 1; pl_rs = ra[i]; pl_rt = rb[i];
            rd_q.push_back({ref_regs[ra[i]], ref_regs[rb[i]]});
            tick();
            idle_inputs();
            chk_cnt++; if (pl_rd_valid !== 1'b1) $display("FAIL byp_valid_%0d: got %b want 1", i, pl_rd_valid); else pass_cnt++;
            if (rd_q.size() > 0) begin
                rd_exp = rd_q.pop_front();
                chk_cnt++; if (pl_rs_data !== rd_exp[2*DW-1:DW]) $display("FAIL byp_rs_%0d: got %h want %h", i, pl_rs_data, rd_exp[2*DW-1:DW]); else pass_cnt++;
                chk_cnt++; if (pl_rt_data !== rd_exp[DW-1:0]) $display("FAIL byp_rt_%0d: got %h want %h", i, pl_rt_data, rd_exp[DW-1:0]); else pass_cnt++;
            end
        end
        tick();
        $display("test_bypass done");
    endtask

    task automatic test_zero();
        pl_we = 1; pl_wa = 0; pl_wd = 32'hFFFFFFFF;
        pl_rd_en = 1; pl_rs = 0; pl_rt = 0;
        rd_q.push_back({ref_regs[0], ref_regs[0]});
        #1;
        chk_cnt++; if (rf_we3 !== 1'b0) $display("FAIL zero_pl_we3: got %b want 0", rf_we3); else pass_cnt++;
        tick();
        idle_inputs();
        chk_cnt++; if (pl_rd_valid !== 1'b1) $display("FAIL zero_valid: got %b want 1", pl_rd_valid); else pass_cnt++;
        if (rd_q.size() > 0) begin
            rd_exp = rd_q.pop_front();
            chk_cnt++; if (pl_rs_data !== rd_exp[2*DW-1:DW]) $display("FAIL zero_rs: got %h want %h", pl_rs_data, rd_exp[2*DW-1:DW]); else pass_cnt++;
            chk_cnt++; if (pl_rt_data !== rd_exp[DW-1:0]) $display("FAIL zero_rt: got %h want %h", pl_rt_data, rd_exp[DW-1:0]); else pass_cnt++;
        end
        dbg_wr_valid = 1; dbg_wa = 0; dbg_wd = 32'hFFFFFFFF;
        #1;
        chk_cnt++; if (dbg_wr_ready !== 1'b1 || rf_we3 !== 1'b0)
            $display("FAIL zero_dbg: got ready=%b we3=%b want 1/0", dbg_wr_ready, rf_we3); else pass_cnt++;
        tick();
        idle_inputs();
        $display("test_zero done");
    endtask

    task automatic test_write_conflict();
        pl_we = 1; pl_wa = 9; pl_wd = 32'h00009999;
        dbg_wr_valid = 1; dbg_wa = 10; dbg_wd = 32'h0000AAAA;
        ref_regs[9] = 32'h00009999;
        #1;
        chk_cnt++; if (dbg_wr_ready !== 1'b0) $display("FAIL conf_ready_lo: got %b want 0", dbg_wr_ready); else pass_cnt++;
        chk_cnt++; if (rf_a3 !== 5'd9 || rf_wd3 !== 32'h00009999 || rf_we3 !== 1'b1)
            $display("FAIL conf_pl_sel: got a=%0d d=%h we=%b want 9/00009999/1", rf_a3, rf_wd3, rf_we3); else pass_cnt++;
        tick();
        pl_we = 0;
        ref_regs[10] = 32'h0000AAAA;
        #1;
        chk_cnt++; if (dbg_wr_ready !== 1'b1) $display("FAIL conf_ready_hi: got %b want 1", dbg_wr_ready); else pass_cnt++;
        chk_cnt++; if (rf_a3 !== 5'd10 || rf_wd3 !== 32'h0000AAAA || rf_we3 !== 1'b1)
            $display("FAIL conf_dbg_sel: got a=%0d d=%h we=%b want 10/0000aaaa/1", rf_a3, rf_wd3, rf_we3); else pass_cnt++;
        tick();
        idle_inputs();
        pl_rd_en = 1; pl_rs = 9; pl_rt = 10;
        rd_q.push_back({ref_regs[9], ref_regs[10]});
        tick();
        idle_inputs();
        chk_cnt++; if (pl_rd_valid !== 1'b1) $display("FAIL conf_valid: got %b want 1", pl_rd_valid); else pass_cnt++;
        if (rd_q.size() > 0) begin
            rd_exp = rd_q.pop_front();
            chk_cnt++; if (pl_rs_data !== rd_exp[2*DW-1:DW]) $display("FAIL conf_rs: got %h want %h", pl_rs_data, rd_exp[2*DW-1:DW]); else pass_cnt++;
            chk_cnt++; if (pl_rt_data !== rd_exp[DW-1:0]) $display("FAIL conf_rt: got %h want %h", pl_rt_data, rd_exp[DW-1:0]); else pass_cnt++;
        end
        $display("test_write_conflict done");
    endtask

    task automatic test_full_dump();
        int busy_cycles = 0;
        int words = 0;
        int stall_bad = 0;
        bit rdv_seen = 0;
        for (int i = 1; i < NR; i++) begin
            pl_we = 1; pl_wa = AW'(i); pl_wd = DW'(i * 32'h11);
            ref_regs[i] = DW'(i * 32'h11);
            tick();
        end
        idle_inputs();
        dbg_dump_ready = 1; dbg_dump_start = 1;
        for (int i = 0; i < NR; i++) dump_q.push_back({AW'(i), ref_regs[i]});
        tick();
        dbg_dump_start = 0; pl_rd_en = 1; pl_rs = 3; pl_rt = 4;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!dbg_dump_busy) break;
            busy_cycles++;
            if (pl_rd_valid) rdv_seen = 1;
            if (pl_stall !== dbg_dump_busy) stall_bad++;
            if (dbg_dump_valid && dump_q.size() > 0) begin
                words++;
                dump_exp = dump_q.pop_front();
                chk_cnt++; if (dbg_dump_idx !== dump_exp[AW+DW-1:DW]) $display("FAIL dump_idx: got %0d want %0d", dbg_dump_idx, dump_exp[AW+DW-1:DW]); else pass_cnt++;
                chk_cnt++; if (dbg_dump_data !== dump_exp[DW-1:0]) $display("FAIL dump_data[%0d]: got %h want %h", dbg_dump_idx, dbg_dump_data, dump_exp[DW-1:0]); else pass_cnt++;
            end
            tick();
        end
        pl_rd_en = 0;
        chk_cnt++; if (busy_cycles != 3 * NR) $display("FAIL dump_busy_cycles: got %0d want %0d", busy_cycles, 3 * NR); else pass_cnt++;
        chk_cnt++; if (words != NR) $display("FAIL dump_words: got %0d want %0d", words, NR); else pass_cnt++;
        chk_cnt++; if (stall_bad != 0) $display("FAIL dump_stall: got %0d mismatched cycles want 0", stall_bad); else pass_cnt++;
        tick();
        if (pl_rd_valid) rdv_seen = 1;
        chk_cnt++; if (rdv_seen) $display("FAIL dump_rd_valid: got 1 during dump want 0"); else pass_cnt++;
        dump_q.delete();
        idle_inputs();
        $display("test_full_dump done: %0d words in %0d cycles", words, busy_cycles);
    endtask

    task automatic test_backpressure_abort();
        bit held = 0;
        bit done = 0;
        bit any_valid = 0;
        int words = 0;
        dbg_dump_ready = 1; dbg_dump_start = 1;
        for (int i = 0; i < NR; i++) dump_q.push_back({AW'(i), ref_regs[i]});
        tick();
        dbg_dump_start = 0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            if (dbg_dump_valid) begin
                if (dbg_dump_idx == 3 && !held) begin
                    held = 1;
                    dbg_dump_ready = 0;
                    for (int k = 0; k < 10; k++) begin
                        tick();
                        chk_cnt++; if (dbg_dump_valid !== 1'b1 || dbg_dump_idx !== 5'd3 || dbg_dump_data !== ref_regs[3])
                            $display("FAIL bp_hold_%0d: got v=%b idx=%0d d=%h want 1/3/%h", k, dbg_dump_valid, dbg_dump_idx, dbg_dump_data, ref_regs[3]);
                        else pass_cnt++;
                    end
                    dbg_dump_ready = 1;
                end
                if (dbg_dump_idx == 10) begin
                    done = 1;
                end else if (dump_q.size() > 0) begin
                    dump_exp = dump_q.pop_front();
                    chk_cnt++; if (dbg_dump_idx !== dump_exp[AW+DW-1:DW] || dbg_dump_data !== dump_exp[DW-1:0])
                        $display("FAIL bp_word: got idx=%0d d=%h want %0d/%h", dbg_dump_idx, dbg_dump_data, dump_exp[AW+DW-1:DW], dump_exp[DW-1:0]);
                    else pass_cnt++;
                end
            end
            if (!done) tick();
        end
        chk_cnt++; if (!(held && done)) $display("FAIL bp_reach: got held=%b reached10=%b want 1/1", held, done); else pass_cnt++;
        reset = 0;
        #1;
        chk_cnt++; if (pl_rd_valid !== 0 || pl_rs_data !== '0 || pl_rt_data !== '0 || pl_stall !== 0)
            $display("FAIL abort_pl: got v=%b rs=%h rt=%h stall=%b want all 0", pl_rd_valid, pl_rs_data, pl_rt_data, pl_stall); else pass_cnt++;
        chk_cnt++; if (dbg_dump_busy !== 0 || dbg_dump_valid !== 0 || dbg_dump_idx !== '0 || dbg_dump_data !== '0)
            $display("FAIL abort_dbg: got busy=%b v=%b idx=%0d d=%h want all 0", dbg_dump_busy, dbg_dump_valid, dbg_dump_idx, dbg_dump_data); else pass_cnt++;
        tick(); tick();
        reset = 1;
        dump_q.delete();
        for (int k = 0; k < 8; k++) begin
            tick();
            if (dbg_dump_valid || dbg_dump_busy) any_valid = 1;
        end
        chk_cnt++; if (any_valid) $display("FAIL abort_quiet: got dump activity after reset want none"); else pass_cnt++;

        // Restart; a write lands during the ISSUE cycle of idx 1 and must be reflected in that word.
        dbg_dump_start = 1;
        dump_q.push_back({AW'(0), ref_regs[0]});
        dump_q.push_back({AW'(1), 32'hCAFE0001});
        tick();
        dbg_dump_start = 0;
        for (int k = 1; k < 40; k++) begin
            if (k == 4) begin
                pl_we = 1; pl_wa = 1; pl_wd = 32'hCAFE0001; ref_regs[1] = 32'hCAFE0001;
            end else begin
                pl_we = 0;
            end
            if (dbg_dump_valid && dump_q.size() > 0) begin
                words++;
                dump_exp = dump_q.pop_front();
                chk_cnt++; if (dbg_dump_idx !== dump_exp[AW+DW-1:DW] || dbg_dump_data !== dump_exp[DW-1:0])
                    $display("FAIL restart_word: got idx=%0d d=%h want %0d/%h", dbg_dump_idx, dbg_dump_data, dump_exp[AW+DW-1:DW], dump_exp[DW-1:0]);
                else pass_cnt++;
            end
            if (words == 2) break;
            tick();
        end
        chk_cnt++; if (words != 2) $display("FAIL restart_words: got %0d want 2", words); else pass_cnt++;
        idle_inputs();
        reset = 0;
        tick();
        reset = 1;
        tick();
        $display("test_backpressure_abort done");
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            rf_mem[i]   = 32'hBAD00000 | DW'(i);
            ref_regs[i] = 32'hBAD00000 | DW'(i);
        end
        ref_regs[0] = '0;
        idle_inputs();
        test_reset();
        test_write_read();
        test_bypass();
        test_zero();
        test_write_conflict();
        test_full_dump();
        test_backpressure_abort();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
- Sits between the pipeline, the debug unit and the 32x32 register file.
- The register file has one write port and two read ports. Its reads are registered, so data appears one cycle after the address.
- This block:
  - arbitrates the write port between pipeline writeback and debug writes;
  - hides the read latency hazard with same-cycle write bypass;
  - enforces $0 semantics;
  - runs a sequential dump FSM that streams all registers to the debug unit while stalling pipeline reads.

Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, register address width
- NREGS, 32, registers dumped (indices 0..NREGS-1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- pl_rd_en  in  1  pipeline read request this cycle
- pl_rs  in  ADDR_W  pipeline source address 1
- pl_rt  in  ADDR_W  pipeline source address 2
- pl_we  in  1  pipeline writeback enable
- pl_wa  in  ADDR_W  writeback address
- pl_wd  in  DATA_W  writeback data
- pl_rs_data  out  DATA_W  read data for pl_rs
- pl_rt_data  out  DATA_W  read data for pl_rt
- pl_rd_valid  out  1  read data valid, one cycle after an accepted request
- pl_stall  out  1  debug owns the read ports; pipeline must hold
- dbg_wr_valid  in  1  debug write request
- dbg_wr_ready  out  1  debug write accepted this cycle
- dbg_wa  in  ADDR_W  debug write address
- dbg_wd  in  DATA_W  debug write data
- dbg_dump_start  in  1  start-of-dump pulse
- dbg_dump_busy  out  1  dump in progress
- dbg_dump_valid  out  1  dump word valid
- dbg_dump_ready  in  1  consumer accepts dump word
- dbg_dump_idx  out  ADDR_W  index of the current dump word
- dbg_dump_data  out  DATA_W  current dump word
- rf_a1, rf_a2, rf_a3  out  ADDR_W  register-file read1/read2/write addresses
- rf_wd3  out  DATA_W  register-file write data
- rf_we3  out  1  register-file write enable
- rf_rd1, rf_rd2  in  DATA_W  registered read data from the register file

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM returns to IDLE and idx=0.
  - All registered outputs go to 0: pl_rd_valid, pl_rs_data, pl_rt_data, pl_stall, dbg_dump_busy, dbg_dump_valid, dbg_dump_idx, dbg_dump_data.
  - A reset mid-dump aborts the dump; no further dump words are issued.
- Write arbitration (combinational):
  - Pipeline has priority over debug.
  - dbg_wr_ready = reset & !pl_we.
  - Selected requester drives rf_a3 and rf_wd3.
  - rf_we3 = (pl_we | (dbg_wr_valid & dbg_wr_ready)) & (selected address != 0).
  - A write to $0 still completes its handshake but is dropped.
  - Pipeline writes are accepted in every FSM state.
- Pipeline read:
  - In IDLE: rf_a1=pl_rs and rf_a2=pl_rt.
  - A request in cycle N is accepted only in IDLE. pl_rd_valid=1 in cycle N+1 only if accepted.
  - Data for each port in N+1:
    - address 0: returns 0;
    - else, if rf_we3 was active in N and rf_a3 equals that address: returns rf_wd3 captured in N (bypass);
    - else: returns rf_rd1 / rf_rd2.
  - pl_rs_data and pl_rt_data hold their last value when not valid.
- Dump FSM states: IDLE, ISSUE, WAIT, VALID.
- IDLE:
  - dbg_dump_start=1 moves to ISSUE with idx=0.
  - A pipeline read in the same cycle is still serviced.
- ISSUE:
  - rf_a1=idx.
  - Bypass compare against this cycle's write.
  - Next state: WAIT.
- WAIT:
  - Latches into dbg_dump_data: 0 if idx=0, else the bypassed value, else rf_rd1.
  - dbg_dump_idx=idx.
  - Next state: VALID.
- VALID:
  - dbg_dump_valid=1.
  - Data and idx are held stable until dbg_dump_ready=1.
  - On handshake: if idx=NREGS-1, go to IDLE; else idx+1 and go to ISSUE.
- pl_stall = dbg_dump_busy = (state != IDLE). Both are registered and rise the cycle after the start pulse.
- dbg_dump_start is ignored while busy.
- Each dumped value is the register content as of its own ISSUE cycle; the dump is not an atomic snapshot.
- Minimum dump time: 3*NREGS cycles, plus backpressure.
- rf_a2 is driven with pl_rt in all states.

Test Plan:
- Write/read: pl_we, pl_wa=5, pl_wd=0xDEADBEEF; next cycle pl_rd_en with pl_rs=5 -> pl_rd_valid=1 one cycle later, pl_rs_data=0xDEADBEEF.
- Bypass: same cycle pl_we to addr 7 with 0x12345678 and pl_rd_en with pl_rs=7, pl_rt=7 -> both outputs 0x12345678 next cycle, not the stale value.
- $0 handling: pl_we to addr 0 with 0xFFFFFFFF -> rf_we3=0; a later read of rs=0 returns 0.
- Write conflict: dbg_wr_valid and pl_we in the same cycle -> dbg_wr_ready=0 and the pipeline write lands. Next cycle pl_we=0 -> dbg_wr_ready=1 and the debug write lands.
- Full dump: preload reg i = i*0x11; dump with dbg_dump_ready always 1 -> 32 words, idx 0..31, data i*0x11 (idx 0 gives 0); busy and stall high for 96 cycles; pl_rd_en during the dump gives no pl_rd_valid.
- Backpressure and abort:
  - Hold dbg_dump_ready=0 for 10 cycles on idx 3 -> valid, idx and data stable.
  - Assert reset at idx 10 -> all outputs 0, IDLE; a new dump_start restarts at idx 0.
